// File: rtl/rs_pkg.sv
// rs_pkg: shared types and helpers for the ShiftRows / InvShiftRows stage.
//   ROW_W     - width of one state row word (4 bytes)
//   NROWS     - rows per AES state
//   row_t     - one row word; bits [31:24] are column 0 and [7:0] are column 3
//   state_t   - packed array of NROWS row words
//   rot_bytes - cyclic byte rotation of a row word, left or right
package rs_pkg;

   localparam int unsigned ROW_W = 32;
   localparam int unsigned NROWS = 4;

   typedef logic [ROW_W-1:0] row_t;
   typedef row_t [NROWS-1:0] state_t;

   // Rotate 'row' by n bytes (modulo 4). A right rotation by n is the same as a
   // left rotation by (4 - n) mod 4, so only the left form is built. The word is
   // doubled so the rotation becomes a single 32-bit window into 64 bits.
   function automatic row_t rot_bytes(row_t row, int n, bit right);
      logic [2*ROW_W-1:0] dbl;
      int unsigned        lft;
      dbl = {row, row};
      if (right) begin
         lft = unsigned'((4 - (n & 3)) & 3);
      end else begin
         lft = unsigned'(n & 3);
      end
      return dbl[(ROW_W - 8 * lft) +: ROW_W];
   endfunction

   // Even parity of one row word.
   function automatic logic row_parity(row_t row);
      return ^row;
   endfunction

endpackage

// File: rtl/rs_row_rot.sv
// rs_row_rot: combinational byte rotator for a single state row.
// Ports:
//   row_i  - input row word
//   amt_i  - rotation amount in bytes (0..3)
//   dir_i  - 0 = rotate left (encrypt), 1 = rotate right (decrypt)
//   row_o  - rotated row word
module rs_row_rot
   import rs_pkg::*;
(
   input  row_t       row_i,
   input  logic [1:0] amt_i,
   input  logic       dir_i,
   output row_t       row_o
);

   always_comb begin
      row_o = rot_bytes(row_i, int'(amt_i), dir_i);
   end

endmodule

// File: rtl/rs.sv
// rs: registered AES ShiftRows / InvShiftRows stage, one-cycle latency.
// Row r of the state is rotated by r bytes: left when encrypting, right when
// decrypting. Row 0 always passes through; row 2 is the same in both directions.
// Ports:
//   clk       - rising-edge clock
//   rst       - synchronous active-high reset, has priority over valid_i
//   valid_i   - state_i / enc_dec carry a beat this cycle
//   enc_dec   - 0 = encrypt (rotate left), 1 = decrypt (rotate right)
//   state_i   - input rows, state_i[r] = row r
//   valid_o   - state_o holds a freshly shifted state
//   state_o   - shifted rows, held while valid_i is low
//   parity_o  - per-row even parity of state_o (only when RS_PARITY_EN is defined)
// Configuration macro: RS_PARITY_EN adds the registered parity_o output.
module rs #(
   parameter int unsigned WORD_W = 32,
   parameter int unsigned NROWS  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_i,
   input  logic              enc_dec,
   input  logic [WORD_W-1:0] state_i [NROWS],
   output logic              valid_o,
   output logic [WORD_W-1:0] state_o [NROWS]
`ifdef RS_PARITY_EN
   ,
   output logic [NROWS-1:0]  parity_o
`endif
);

   import rs_pkg::*;

   row_t shifted [NROWS];

   logic valid_d, valid_q;
   row_t state_d [NROWS];
   row_t state_q [NROWS];

   // One rotator per row; the rotation amount is the row index.
   for (genvar r = 0; r < NROWS; r++) begin : gen_row
      rs_row_rot u_row_rot (
         .row_i (state_i[r]),
         .amt_i (2'(r)),
         .dir_i (enc_dec),
         .row_o (shifted[r])
      );
   end

`ifdef RS_PARITY_EN
   logic [NROWS-1:0] parity_d, parity_q;
`endif

   always_comb begin
      valid_d = valid_i;
      state_d = state_q;
`ifdef RS_PARITY_EN
      parity_d = parity_q;
`endif
      if (valid_i) begin
         for (int r = 0; r < NROWS; r++) begin
            state_d[r] = shifted[r];
`ifdef RS_PARITY_EN
            // Rotation only permutes bytes, so this also equals ^state_i[r].
            parity_d[r] = row_parity(shifted[r]);
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         for (int r = 0; r < NROWS; r++) begin
            state_q[r] <= '0;
         end
`ifdef RS_PARITY_EN
         parity_q <= '0;
`endif
      end else begin
         valid_q <= valid_d;
         state_q <= state_d;
`ifdef RS_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   assign valid_o = valid_q;
   assign state_o = state_q;
`ifdef RS_PARITY_EN
   assign parity_o = parity_q;
`endif

endmodule

// File: tb/tb_rs.sv
// tb_rs: self-checking bench for the rs ShiftRows stage. A byte-level reference
// model (column c of the output row takes column (c +/- r) mod 4 of the input)
// predicts every beat. Parity is also checked when RS_PARITY_EN is defined.
module tb_rs;

   logic        clk;
   logic        rst;
   logic        valid_i;
   logic        enc_dec;
   logic [31:0] state_i [4];
   logic        valid_o;
   logic [31:0] state_o [4];
`ifdef RS_PARITY_EN
   logic [3:0]  parity_o;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   rs u_dut (
      .clk      (clk),
      .rst      (rst),
      .valid_i  (valid_i),
      .enc_dec  (enc_dec),
      .state_i  (state_i),
      .valid_o  (valid_o),
      .state_o  (state_o)
`ifdef RS_PARITY_EN
      ,
      .parity_o (parity_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Protocol: direction must be known whenever a beat is presented.
   always @(posedge clk) begin
      if (!rst && valid_i === 1'b1) begin
         assert (!$isunknown(enc_dec))
         else $error("enc_dec unknown while valid_i is high");
      end
   end

   // Reference model: byte-wise rotation from column indices.
   function automatic logic [31:0] model_row(logic [31:0] w, int r, bit dec);
      logic [7:0] in_b  [4];
      logic [7:0] out_b [4];
      for (int c = 0; c < 4; c++) in_b[c] = w[31 - 8 * c -: 8];
      for (int c = 0; c < 4; c++) begin
         if (dec) out_b[c] = in_b[(c - r + 4) % 4];
         else     out_b[c] = in_b[(c + r) % 4];
      end
      return {out_b[0], out_b[1], out_b[2], out_b[3]};
   endfunction

   function automatic logic [127:0] model_state(logic [127:0] s, bit dec);
      logic [127:0] o;
      for (int r = 0; r < 4; r++) o[127 - 32 * r -: 32] = model_row(s[127 - 32 * r -: 32], r, dec);
      return o;
   endfunction

   // Row 0 in the top 32 bits.
   function automatic logic [127:0] out_flat();
      return {state_o[0], state_o[1], state_o[2], state_o[3]};
   endfunction

   function automatic logic [3:0] model_parity(logic [127:0] s);
      logic [3:0] p;
      for (int r = 0; r < 4; r++) p[r] = ^s[127 - 32 * r -: 32];
      return p;
   endfunction

   task automatic drive(input logic v, input logic d, input logic [127:0] s);
      valid_i = v;
      enc_dec = d;
      for (int r = 0; r < 4; r++) state_i[r] = s[127 - 32 * r -: 32];
   endtask

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   localparam logic [127:0] VEC     = 128'h01234567_456789AB_89ABCDEF_CDEF0123;
   localparam logic [127:0] VEC_ENC = 128'h01234567_6789AB45_CDEF89AB_23CDEF01;
   localparam logic [127:0] VEC_DEC = 128'h01234567_AB456789_CDEF89AB_EF0123CD;

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b1, 1'b0, VEC);
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid cycle %0d: got %b want 0", i, valid_o);
         end
         n_checks++;
         if (out_flat() !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_state cycle %0d: got %h want 0", i, out_flat());
         end
`ifdef RS_PARITY_EN
         n_checks++;
         if (parity_o !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_parity cycle %0d: got %h want 0", i, parity_o);
         end
`endif
      end
      rst = 1'b0;
      drive(1'b0, 1'b0, 128'h0);
      tick();
   endtask

   task automatic test_single(input bit dec, input logic [127:0] want, input string name);
      logic [127:0] model;
      drive(1'b1, dec, VEC);
      tick();
      drive(1'b0, 1'b0, 128'h0);
      model = model_state(VEC, dec);
      n_checks++;
      if (valid_o !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_valid: got %b want 1", name, valid_o);
      end
      n_checks++;
      if (out_flat() !== want) begin
         n_fail++;
         $display("FAIL %s_state: got %h want %h", name, out_flat(), want);
      end
      n_checks++;
      if (out_flat() !== model) begin
         n_fail++;
         $display("FAIL %s_model: got %h want %h", name, out_flat(), model);
      end
`ifdef RS_PARITY_EN
      n_checks++;
      if (parity_o !== model_parity(VEC)) begin
         n_fail++;
         $display("FAIL %s_parity: got %h want %h", name, parity_o, model_parity(VEC));
      end
`endif
      tick();
   endtask

   task automatic test_back_to_back();
      drive(1'b1, 1'b0, VEC);
      tick();
      drive(1'b1, 1'b1, VEC);
      n_checks++;
      if (valid_o !== 1'b1 || out_flat() !== VEC_ENC) begin
         n_fail++;
         $display("FAIL b2b_first: got v=%b %h want v=1 %h", valid_o, out_flat(), VEC_ENC);
      end
      tick();
      drive(1'b0, 1'b0, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555);
      n_checks++;
      if (valid_o !== 1'b1 || out_flat() !== VEC_DEC) begin
         n_fail++;
         $display("FAIL b2b_second: got v=%b %h want v=1 %h", valid_o, out_flat(), VEC_DEC);
      end
      tick();
      n_checks++;
      if (valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_idle_valid: got %b want 0", valid_o);
      end
      n_checks++;
      if (out_flat() !== VEC_DEC) begin
         n_fail++;
         $display("FAIL b2b_hold: got %h want %h", out_flat(), VEC_DEC);
      end
      // Toggling direction with no beat must not disturb the held output.
      enc_dec = 1'b1;
      tick();
      enc_dec = 1'b0;
      tick();
      n_checks++;
      if (valid_o !== 1'b0 || out_flat() !== VEC_DEC) begin
         n_fail++;
         $display("FAIL idle_toggle: got v=%b %h want v=0 %h", valid_o, out_flat(), VEC_DEC);
      end
   endtask

   task automatic test_round_trip();
      logic [127:0] s, enc_model;
      int           bad = 0;
      for (int i = 0; i < 1000; i++) begin
         s = {$urandom, $urandom, $urandom, $urandom};
         drive(1'b1, 1'b0, s);
         tick();
         enc_model = model_state(s, 1'b0);
         n_checks++;
         if (valid_o !== 1'b1 || out_flat() !== enc_model) begin
            n_fail++;
            bad++;
            if (bad < 5) $display("FAIL rt_enc %0d: got %h want %h", i, out_flat(), enc_model);
         end
`ifdef RS_PARITY_EN
         n_checks++;
         if (parity_o !== model_parity(s)) begin
            n_fail++;
            bad++;
            if (bad < 5) $display("FAIL rt_parity %0d: got %h want %h", i, parity_o, model_parity(s));
         end
`endif
         drive(1'b1, 1'b1, out_flat());
         tick();
         n_checks++;
         if (valid_o !== 1'b1 || out_flat() !== s) begin
            n_fail++;
            bad++;
            if (bad < 5) $display("FAIL rt_dec %0d: got %h want %h", i, out_flat(), s);
         end
      end
      drive(1'b0, 1'b0, 128'h0);
      tick();
   endtask

   task automatic test_reset_midstream();
      logic [127:0] s;
      s = {$urandom, $urandom, $urandom, $urandom} | 128'h1;
      drive(1'b1, 1'b0, s);
      tick();
      n_checks++;
      if (out_flat() !== model_state(s, 1'b0)) begin
         n_fail++;
         $display("FAIL mid_pre: got %h want %h", out_flat(), model_state(s, 1'b0));
      end
      rst = 1'b1;
      drive(1'b1, 1'b1, ~s);
      tick();
      rst = 1'b0;
      drive(1'b0, 1'b0, 128'h0);
      n_checks++;
      if (valid_o !== 1'b0 || out_flat() !== 128'h0) begin
         n_fail++;
         $display("FAIL mid_reset: got v=%b %h want v=0 0", valid_o, out_flat());
      end
`ifdef RS_PARITY_EN
      n_checks++;
      if (parity_o !== 4'h0) begin
         n_fail++;
         $display("FAIL mid_reset_parity: got %h want 0", parity_o);
      end
`endif
      tick();
      n_checks++;
      if (valid_o !== 1'b0 || out_flat() !== 128'h0) begin
         n_fail++;
         $display("FAIL mid_after: got v=%b %h want v=0 0", valid_o, out_flat());
      end
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 1'b0, 128'h0);
      test_reset();
      test_single(1'b0, VEC_ENC, "encrypt");
      test_single(1'b1, VEC_DEC, "decrypt");
      test_back_to_back();
      test_round_trip();
      test_reset_midstream();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
